// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM state encoding and oversampling constants.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        START    = 3'd1,
        DATA     = 3'd2,
        STOP     = 3'd3,
        BRK_WAIT = 3'd4
    } state_t;

    localparam int OVS = 16;
    localparam int MID = 7;

endpackage

// File: rtl/uart_rx_frontend_if.sv
// Receive-side bundle: serial line in, assembled byte with done/error flags and the oversample tick out.
interface uart_rx_frontend_if #(
    parameter int DBIT = 8
);
    logic            i_rx;
    logic [DBIT-1:0] o_data;
    logic            o_rx_done_tick;
    logic            o_frame_err;
    logic            o_s_tick;

    modport master (
        input  i_rx,
        output o_data,
        output o_rx_done_tick,
        output o_frame_err,
        output o_s_tick
    );

    modport slave (
        output i_rx,
        input  o_data,
        input  o_rx_done_tick,
        input  o_frame_err,
        input  o_s_tick
    );
endinterface

// File: rtl/uart_rx_frontend_baud_tick_gen.sv
// Free-running mod-DVSR counter producing a one-clock oversample tick; shared with the transmitter.
module baud_tick_gen #(
    parameter int DVSR      = 163,
    parameter int DVSR_BITS = 9
) (
    input  logic i_clk,
    input  logic i_reset_n,
    output logic o_s_tick
);
    localparam logic [DVSR_BITS-1:0] LAST = DVSR_BITS'(DVSR - 1);

    logic [DVSR_BITS-1:0] cnt;

    // Count 0..DVSR-1 and wrap; the tick is the terminal count.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign o_s_tick = (cnt == LAST);

endmodule

// File: rtl/uart_rx_frontend.sv
// UART receive front end: two-flop line synchroniser, 16x oversampling deframer, break handling.
module uart_rx_frontend
    import uart_pkg::*;
#(
    parameter int DBIT      = 8,
    parameter int SB_TICK   = 16,
    parameter int DVSR      = 163,
    parameter int DVSR_BITS = 9
) (
    input  logic                i_clk,
    input  logic                i_reset_n,
    uart_rx_frontend_if.master  rx_if
);
    localparam int N_W = (DBIT > 1) ? $clog2(DBIT) : 1;
    localparam int S_W = $clog2((SB_TICK > OVS) ? SB_TICK : OVS);

    logic            rx_meta_p0;
    logic            rx_s;
    logic            s_tick;

    state_t          state, state_nxt;
    logic [S_W-1:0]  s, s_nxt;
    logic [N_W-1:0]  n, n_nxt;
    logic [DBIT-1:0] b, b_nxt;
    logic [DBIT-1:0] data, data_nxt;
    logic            done, done_nxt;
    logic            ferr, ferr_nxt;

    baud_tick_gen #(
        .DVSR      (DVSR),
        .DVSR_BITS (DVSR_BITS)
    ) u_baud_tick_gen (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .o_s_tick  (s_tick)
    );

    // Two-flop synchroniser on the asynchronous line, reset to the idle level.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            rx_meta_p0 <= 1'b1;
            rx_s       <= 1'b1;
        end else begin
            rx_meta_p0 <= rx_if.i_rx;
            rx_s       <= rx_meta_p0;
        end
    end

    // FSM state, counters, shift register and registered outputs.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state <= IDLE;
            s     <= '0;
            n     <= '0;
            b     <= '0;
            data  <= '0;
            done  <= 1'b0;
            ferr  <= 1'b0;
        end else begin
            state <= state_nxt;
            s     <= s_nxt;
            n     <= n_nxt;
            b     <= b_nxt;
            data  <= data_nxt;
            done  <= done_nxt;
            ferr  <= ferr_nxt;
        end
    end

    // Next-state logic: verify start at its midpoint, sample each bit 16 ticks later, check stop.
    always_comb begin
        state_nxt = state;
        s_nxt     = s;
        n_nxt     = n;
        b_nxt     = b;
        data_nxt  = data;
        done_nxt  = 1'b0;
        ferr_nxt  = ferr;
        case (state)
            IDLE: begin
                if (!rx_s) begin
                    state_nxt = START;
                    s_nxt     = '0;
                end
            end
            START: begin
                if (s_tick) begin
                    if (s == S_W'(MID)) begin
                        if (!rx_s) begin
                            state_nxt = DATA;
                            s_nxt     = '0;
                            n_nxt     = '0;
                        end else begin
                            state_nxt = IDLE;
                        end
                    end else begin
                        s_nxt = s + 1'b1;
                    end
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (s == S_W'(OVS - 1)) begin
                        s_nxt = '0;
                        b_nxt = {rx_s, b[DBIT-1:1]};
                        if (n == N_W'(DBIT - 1)) begin
                            state_nxt = STOP;
                        end else begin
                            n_nxt = n + 1'b1;
                        end
                    end else begin
                        s_nxt = s + 1'b1;
                    end
                end
            end
            STOP: begin
                if (s_tick) begin
                    if (s == S_W'(SB_TICK - 1)) begin
                        data_nxt  = b;
                        done_nxt  = 1'b1;
                        ferr_nxt  = ~rx_s;
                        state_nxt = rx_s ? IDLE : BRK_WAIT;
                    end else begin
                        s_nxt = s + 1'b1;
                    end
                end
            end
            BRK_WAIT: begin
                if (rx_s) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign rx_if.o_data         = data;
    assign rx_if.o_rx_done_tick = done;
    assign rx_if.o_frame_err    = ferr;
    assign rx_if.o_s_tick       = s_tick;

endmodule
